// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register of the RV32 core with load-use bubble
// insertion, flush/hold handling and a saturating bubble counter.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_op,
  input  logic [10:0]      id_ctrl,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             load_use_stall,
  output logic             ex_valid,
  output logic [10:0]      ex_ctrl,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
  } exData_t;

  logic             exValid_q, exValid_d;
  logic [10:0]      exCtrl_q, exCtrl_d;
  exData_t          exData_q, exData_d, idData;
  logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
  logic             usesRs1, usesRs2, exLoad;

  always_comb begin
    usesRs1 = 1'b0;
    usesRs2 = 1'b0;
    case (id_op)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        usesRs1 = 1'b1;
        usesRs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: usesRs1 = 1'b1;
      default: ;
    endcase
  end

  // A load writing x0 produces nothing to wait for, so it never stalls.
  assign exLoad = exValid_q & exCtrl_q[5] & ~exCtrl_q[4] & (exData_q.rd != 5'd0);
  assign load_use_stall = ~flush & id_valid & exLoad &
                          ((usesRs1 & (id_rs1 == exData_q.rd)) |
                           (usesRs2 & (id_rs2 == exData_q.rd)));

  assign idData = '{pc: id_pc, rs1Data: id_rs1_data, rs2Data: id_rs2_data,
                    imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    funct3: id_funct3, funct7: id_funct7};

  // Killing the slot (flush or bubble) clears only valid/ctrl; data is left as-is.
  always_comb begin
    exValid_d   = exValid_q;
    exCtrl_d    = exCtrl_q;
    exData_d    = exData_q;
    bubbleCnt_d = bubbleCnt_q;
    if (flush) begin
      exValid_d = 1'b0;
      exCtrl_d  = 11'd0;
    end else if (ex_stall) begin
      exValid_d = exValid_q;
    end else if (load_use_stall) begin
      exValid_d = 1'b0;
      exCtrl_d  = 11'd0;
      if (bubbleCnt_q != {CNT_W{1'b1}}) begin
        bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
      end
    end else begin
      exValid_d = id_valid;
      exCtrl_d  = id_valid ? id_ctrl : 11'd0;
      exData_d  = idData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exValid_q   <= 1'b0;
      exCtrl_q    <= 11'd0;
      exData_q    <= '0;
      bubbleCnt_q <= '0;
    end else begin
      exValid_q   <= exValid_d;
      exCtrl_q    <= exCtrl_d;
      exData_q    <= exData_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign ex_valid    = exValid_q;
  assign ex_ctrl     = exCtrl_q;
  assign ex_pc       = exData_q.pc;
  assign ex_rs1_data = exData_q.rs1Data;
  assign ex_rs2_data = exData_q.rs2Data;
  assign ex_imm      = exData_q.imm;
  assign ex_rs1      = exData_q.rs1;
  assign ex_rs2      = exData_q.rs2;
  assign ex_rd       = exData_q.rd;
  assign ex_funct3   = exData_q.funct3;
  assign ex_funct7   = exData_q.funct7;
  assign bubble_cnt  = bubbleCnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage; a second instance with a
// 4-bit counter shares the stimulus to exercise counter saturation.
module tb_id_ex_stage;

  localparam logic [10:0] CTRL_ADD = 11'b00_10_1_0_0_0_0_0_0;
  localparam logic [10:0] CTRL_LW  = 11'b00_01_1_1_0_0_0_1_0;
  localparam logic [6:0]  OP_R = 7'b0110011, OP_LW = 7'b0000011, OP_LUI = 7'b0110111;
  localparam int VW = 165;

  logic clk = 1'b0, rst = 1'b1;
  logic id_valid, flush, ex_stall;
  logic [6:0] id_op, id_funct7;
  logic [10:0] id_ctrl;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;

  logic load_use_stall, ex_valid;
  logic [10:0] ex_ctrl;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [6:0] ex_funct7;
  logic [15:0] bubble_cnt;

  logic s_stall, s_valid;
  logic [10:0] s_ctrl;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0] s_rs1, s_rs2, s_rd;
  logic [2:0] s_funct3;
  logic [6:0] s_funct7;
  logic [3:0] s_cnt;

  int tests = 0, fails = 0;

  // Reference state of the EX slot, tracked from the rules of the stage.
  logic m_valid;
  logic [10:0] m_ctrl;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic [2:0] m_f3;
  logic [6:0] m_f7;
  int m_cnt16, m_cnt4;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_ctrl(id_ctrl),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7(id_funct7), .flush(flush), .ex_stall(ex_stall),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_ctrl(id_ctrl),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7(id_funct7), .flush(flush), .ex_stall(ex_stall),
    .load_use_stall(s_stall), .ex_valid(s_valid), .ex_ctrl(s_ctrl),
    .ex_pc(s_pc), .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct3(s_funct3),
    .ex_funct7(s_funct7), .bubble_cnt(s_cnt)
  );

  wire [VW-1:0] dutVec = {ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                          ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7};

  function automatic logic [VW-1:0] expVec();
    return {m_valid, m_ctrl, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_f3, m_f7};
  endfunction

  function automatic logic modelStall();
    logic readsRs1, readsRs2, exIsLoad;
    readsRs1 = id_op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                             7'b0100011, 7'b1100011};
    readsRs2 = id_op inside {7'b0110011, 7'b0100011, 7'b1100011};
    exIsLoad = m_valid && m_ctrl[5] && !m_ctrl[4] && m_rd != 0;
    return !flush && id_valid && exIsLoad &&
           ((readsRs1 && id_rs1 == m_rd) || (readsRs2 && id_rs2 == m_rd));
  endfunction

  function automatic void modelUpdate(input logic stall);
    if (rst) begin
      {m_valid, m_ctrl, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_f3, m_f7} = '0;
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else if (flush) begin
      m_valid = 1'b0;
      m_ctrl  = '0;
    end else if (ex_stall) begin
      m_valid = m_valid;
    end else if (stall) begin
      m_valid = 1'b0;
      m_ctrl  = '0;
      m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
      m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
    end else begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? id_ctrl : 11'd0;
      m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_f3 = id_funct3; m_f7 = id_funct7;
    end
  endfunction

  task automatic tick();
    logic expStall;
    expStall = modelStall();
    @(posedge clk);
    modelUpdate(expStall);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [10:0] ctrl,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_valid = v; id_op = op; id_ctrl = ctrl;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'($urandom); ex_stall = 1'($urandom);
    repeat (2) begin
      applyStimulus(1'($urandom), 7'($urandom), 11'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      tick();
    end
    tests++;
    if (dutVec !== '0) begin fails++; $display("[TB] FAIL reset_outputs got %h want 0", dutVec); end
    tests++;
    if (bubble_cnt !== 16'd0 || s_cnt !== 4'd0) begin
      fails++; $display("[TB] FAIL reset_cnt got %0d/%0d want 0", bubble_cnt, s_cnt);
    end
    rst = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    applyStimulus(1'b1, OP_R, CTRL_ADD, 5'd0, 5'd0, 5'd1);
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall got %b want 0", load_use_stall); end
  endtask

  task automatic test_pass_through();
    applyStimulus(1'b1, OP_R, CTRL_ADD, 5'd1, 5'd2, 5'd3);
    id_pc = 32'h100; id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_imm = 32'd0;
    id_funct3 = 3'd0; id_funct7 = 7'd0;
    tick();
    tests++;
    if ({ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data} !==
        {1'b1, CTRL_ADD, 32'h100, 32'd5, 32'd7}) begin
      fails++;
      $display("[TB] FAIL pass_through got v=%b c=%b pc=%h a=%0d b=%0d want v=1 c=%b pc=100 a=5 b=7",
               ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, CTRL_ADD);
    end
    tests++;
    if ({ex_rs1, ex_rs2, ex_rd} !== {5'd1, 5'd2, 5'd3}) begin
      fails++; $display("[TB] FAIL pass_indices got %0d %0d %0d want 1 2 3", ex_rs1, ex_rs2, ex_rd);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(1'b1, OP_LW, CTRL_LW, 5'd2, 5'd0, 5'd5);
    tick();
    applyStimulus(1'b1, OP_R, CTRL_ADD, 5'd1, 5'd5, 5'd6);
    #1;
    tests++;
    if (load_use_stall !== 1'b1) begin fails++; $display("[TB] FAIL lu_stall got %b want 1", load_use_stall); end
    tick();
    tests++;
    if ({ex_valid, ex_ctrl, bubble_cnt} !== {1'b0, 11'd0, 16'd1}) begin
      fails++; $display("[TB] FAIL lu_bubble got v=%b c=%h cnt=%0d want v=0 c=0 cnt=1", ex_valid, ex_ctrl, bubble_cnt);
    end
    tests++;
    if (load_use_stall !== 1'b0) begin fails++; $display("[TB] FAIL lu_release got %b want 0", load_use_stall); end
    tick();
    tests++;
    if ({ex_valid, ex_ctrl, ex_rd, ex_rs2} !== {1'b1, CTRL_ADD, 5'd6, 5'd5}) begin
      fails++; $display("[TB] FAIL lu_add_enters got v=%b c=%b rd=%0d want v=1 c=%b rd=6", ex_valid, ex_ctrl, ex_rd, CTRL_ADD);
    end
  endtask

  task automatic test_no_hazard();
    applyStimulus(1'b1, OP_LW, CTRL_LW, 5'd2, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, OP_R, CTRL_ADD, 5'd0, 5'd0, 5'd7);
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin fails++; $display("[TB] FAIL x0_no_stall got %b want 0", load_use_stall); end
    tick();
    applyStimulus(1'b1, OP_LW, CTRL_LW, 5'd2, 5'd0, 5'd5);
    tick();
    applyStimulus(1'b1, OP_LUI, 11'b00_00_1_0_0_0_0_1_0, 5'd5, 5'd5, 5'd5);
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin fails++; $display("[TB] FAIL lui_no_stall got %b want 0", load_use_stall); end
    tick();
    tests++;
    if ({ex_valid, bubble_cnt} !== {1'b1, 16'd1}) begin
      fails++; $display("[TB] FAIL no_hazard_bubble got v=%b cnt=%0d want v=1 cnt=1", ex_valid, bubble_cnt);
    end
  endtask

  task automatic test_flush_stall();
    logic [VW-1:0] snap;
    applyStimulus(1'b1, OP_LW, CTRL_LW, 5'd3, 5'd0, 5'd9);
    tick();
    flush = 1'b1; ex_stall = 1'b1;
    applyStimulus(1'b1, OP_R, CTRL_ADD, 5'd9, 5'd9, 5'd4);
    tick();
    flush = 1'b0; ex_stall = 1'b0;
    tests++;
    if ({ex_valid, ex_ctrl} !== 12'd0 || dutVec !== expVec()) begin
      fails++; $display("[TB] FAIL flush_over_stall got %h want %h", dutVec, expVec());
    end
    applyStimulus(1'b1, OP_R, CTRL_ADD, 5'd1, 5'd2, 5'd3);
    tick();
    snap = expVec();
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, OP_R, 11'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      tick();
      tests++;
      if (dutVec !== snap) begin fails++; $display("[TB] FAIL stall_hold[%0d] got %h want %h", i, dutVec, snap); end
    end
    ex_stall = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, OP_LW, CTRL_LW, 5'd0, 5'd0, 5'(1 + i % 31));
      tick();
      applyStimulus(1'b1, OP_R, CTRL_ADD, 5'(1 + i % 31), 5'd0, 5'd8);
      tick();
    end
    tests++;
    if (s_cnt !== 4'd15) begin fails++; $display("[TB] FAIL sat_cnt4 got %0d want 15", s_cnt); end
    tests++;
    if (bubble_cnt !== 16'd17) begin fails++; $display("[TB] FAIL sat_cnt16 got %0d want 17", bubble_cnt); end
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      ex_stall = ($urandom_range(0, 7) == 0);
      applyStimulus(($urandom_range(0, 5) != 0),
                    ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)],
                    ($urandom_range(0, 2) == 0) ? ((11'($urandom) | 11'h020) & ~11'h010) : 11'($urandom),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      #1;
      tests++;
      if (load_use_stall !== modelStall()) begin
        fails++; errs++;
        if (errs < 10) $display("[TB] FAIL rand_stall[%0d] got %b want %b", i, load_use_stall, modelStall());
      end
      tick();
      tests++;
      if (dutVec !== expVec() || bubble_cnt !== 16'(m_cnt16) || s_cnt !== 4'(m_cnt4)) begin
        fails++; errs++;
        if (errs < 10) $display("[TB] FAIL rand_regs[%0d] got %h cnt=%0d/%0d want %h cnt=%0d/%0d",
                                i, dutVec, bubble_cnt, s_cnt, expVec(), m_cnt16, m_cnt4);
      end
    end
    rst = 1'b0; flush = 1'b0; ex_stall = 1'b0;
  endtask

  initial begin
    {m_valid, m_ctrl, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_f3, m_f7} = '0;
    m_cnt16 = 0;
    m_cnt4  = 0;
    flush = 1'b0;
    ex_stall = 1'b0;
    applyStimulus(1'b0, 7'd0, 11'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_hazard();
    test_flush_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the RV32 core, directly downstream of the main control decoder.
- Registers the decoder's control bundle together with operands, immediate, PC and register indices.
- Detects load-use hazards and inserts a single bubble; supports flush (taken branch/jump) and hold (downstream stall).
- Counts inserted bubbles for performance monitoring.

Parameters:
- XLEN, 32, datapath width of pc/operands/imm.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID slot holds a real instruction.
- id_op  in  7  opcode of ID instruction.
- id_ctrl  in  11  packed decoder outputs {ALU_op[1:0], DMtoReg[1:0], RegWrite, DM_en, DM_write, jump, branch, ALU_src, auipc}, bit 10 down to 0.
- id_pc  in  XLEN  PC of ID instruction.
- id_rs1_data  in  XLEN  rs1 operand.
- id_rs2_data  in  XLEN  rs2 operand.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_funct3  in  3  funct3 field.
- id_funct7  in  7  funct7 field.
- flush  in  1  kill the instruction entering EX (taken branch/jump).
- ex_stall  in  1  downstream hold; freeze the EX register.
- load_use_stall  out  1  combinational; freeze PC and IF/ID for this cycle.
- ex_valid  out  1  EX slot valid.
- ex_ctrl  out  11  registered control bundle, same packing as id_ctrl.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered data.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices.
- ex_funct3  out  3  registered funct3.
- ex_funct7  out  7  registered funct7.
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on rising clk. Reset is synchronous, active-high.
  - On rst: every registered output = 0 (including ex_valid, ex_ctrl, data, indices, bubble_cnt).
- Latency: one cycle from ID inputs to ex_* outputs.
- Register use by opcode:
  - uses_rs1 for op in {0110011 R, 0010011 I, 0000011 LW, 1100111 JALR, 0100011 S, 1100011 B}.
  - uses_rs2 for op in {0110011, 0100011, 1100011}.
  - LUI (0110111), AUIPC (0010111), JAL (1101111) and unknown opcodes use neither register.
- Hazard detection (combinational):
  - ex_load = ex_valid & ex_ctrl[5] (DM_en) & ~ex_ctrl[4] (DM_write) & (ex_rd != 0).
  - load_use_stall = ~flush & id_valid & ex_load & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)).
  - load_use_stall is independent of ex_stall.
- Update priority, one branch taken per cycle:
  1. rst: clear everything.
  2. flush: ex_valid=0, ex_ctrl=0; data and index registers hold. flush overrides ex_stall.
  3. ex_stall: hold all registers; bubble_cnt unchanged.
  4. load_use_stall: insert bubble (ex_valid=0, ex_ctrl=0, data held); bubble_cnt += 1, saturating at all-ones.
  5. Otherwise capture: ex_valid=id_valid; ex_ctrl = id_valid ? id_ctrl : 0; all data, indices and funct fields captured.
- Invariant: ex_valid=0 implies ex_ctrl=0, so an invalid slot never writes a register or memory.
- Consecutive dependent loads: each load-use pair costs exactly one bubble. After the bubble ex_load is 0, so the stall releases in the next cycle.
- x0 destination never triggers a stall.
- Reset mid-stall: rst wins; load_use_stall drops the cycle after rst because ex_valid=0.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all outputs 0, bubble_cnt=0, load_use_stall=0.
- Pass-through: R-type add (id_ctrl=11'b00_10_1_0_0_0_0_0_0, pc=0x100, rs1_data=5, rs2_data=7) -> next cycle ex_valid=1, ex_ctrl and data match exactly.
- Load-use: LW rd=x5 in EX, then ID add with rs2=x5 -> load_use_stall=1 for one cycle, EX shows bubble (ex_valid=0, ex_ctrl=0), bubble_cnt=1; the add enters EX the following cycle.
- No-hazard cases: LW rd=x0 followed by a use of x0, and LW rd=x5 followed by LUI x5 -> load_use_stall=0, no bubble.
- Flush vs stall: flush=1 and ex_stall=1 in the same cycle -> ex_valid=0 next cycle. ex_stall=1 alone for 3 cycles -> ex_* held bit-exact.
- Counter saturation: CNT_W=4, generate 17 load-use hazards -> bubble_cnt stops at 15.
